// File: rtl/lookup_pkg.sv
// Shared definitions for the pipelined lookup engine.
// Node layout, field offsets and the node struct are shared with the update
// controller so that both sides agree on the 72-bit stage memory word.
package lookup_pkg;

   localparam int unsigned NODE_W       = 72;
   localparam int unsigned LOOKUP_KEY_W = 32;
   localparam int unsigned LOOKUP_RES_W = 16;
   localparam int unsigned CHILD_W      = 10;

   localparam int unsigned PIVOT_LSB  = 40;
   localparam int unsigned LEFT_LSB   = 30;
   localparam int unsigned RIGHT_LSB  = 20;
   localparam int unsigned RES_LSB    = 4;
   localparam int unsigned NVALID_BIT = 0;

   typedef struct packed {
      logic [LOOKUP_KEY_W-1:0] pivot;   // [71:40]
      logic [CHILD_W-1:0]      left;    // [39:30]
      logic [CHILD_W-1:0]      right;   // [29:20]
      logic [LOOKUP_RES_W-1:0] result;  // [19:4]
      logic [2:0]              rsvd;    // [3:1]
      logic                    nvalid;  // [0]
   } node_t;

   // Outcome of one tree level for a beat.
   typedef enum logic [2:0] {
      DEC_PASS,   // resolved upstream, forwarded untouched
      DEC_MISS,   // empty node terminates the lookup
      DEC_HIT,    // key equals pivot
      DEC_LEFT,   // key below pivot
      DEC_RIGHT   // key above pivot
   } decision_e;

   // Builds a memory word from its fields; reserved bits are written as zero.
   function automatic logic [NODE_W-1:0] pack_node(
      input logic [LOOKUP_KEY_W-1:0] pivot,
      input logic [CHILD_W-1:0]      left,
      input logic [CHILD_W-1:0]      right,
      input logic [LOOKUP_RES_W-1:0] result,
      input logic                    nvalid
   );
      logic [NODE_W-1:0] w;
      w = '0;
      w[PIVOT_LSB +: LOOKUP_KEY_W] = pivot;
      w[LEFT_LSB  +: CHILD_W]      = left;
      w[RIGHT_LSB +: CHILD_W]      = right;
      w[RES_LSB   +: LOOKUP_RES_W] = result;
      w[NVALID_BIT]                = nvalid;
      return w;
   endfunction

endpackage

// File: rtl/lookup_stage_sat_counter.sv
// sat_counter: saturating up-counter for lookup statistics.
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset, clears count
//   inc_i   increment request (ignored once all ones)
//   clr_i   clear; wins over a same-cycle increment
//   count_o current count
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         count_q <= '0;
      end else if (inc_i && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/lookup_stage.sv
// lookup_stage: one tree level of the pipelined lookup engine.
// Stage 1 registers the incoming beat while the stage memory is read at s_ptr;
// stage 2 compares the key with the node pivot and registers the downstream beat.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_valid/s_key/s_ptr/s_done/s_hit/s_result  upstream beat (no backpressure)
//   mem_addr, mem_dout            stage memory read port (1-cycle read latency)
//   m_valid/m_key/m_ptr/m_done/m_hit/m_result  downstream beat
//   stat_clr                      clears the statistics counters
//   stat_lookups/hits/misses      saturating 32-bit statistics
module lookup_stage
   import lookup_pkg::*;
#(
   parameter int          STAGE_ID  = 0,
   parameter int unsigned DATA      = 72,
   parameter int unsigned ADDR      = 10,
   parameter int unsigned NEXT_ADDR = 10,
   parameter int unsigned KEY_W     = LOOKUP_KEY_W,
   parameter int unsigned RES_W     = LOOKUP_RES_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_valid,
   input  logic [KEY_W-1:0]     s_key,
   input  logic [ADDR-1:0]      s_ptr,
   input  logic                 s_done,
   input  logic                 s_hit,
   input  logic [RES_W-1:0]     s_result,
   output logic [ADDR-1:0]      mem_addr,
   input  logic [DATA-1:0]      mem_dout,
   output logic                 m_valid,
   output logic [KEY_W-1:0]     m_key,
   output logic [NEXT_ADDR-1:0] m_ptr,
   output logic                 m_done,
   output logic                 m_hit,
   output logic [RES_W-1:0]     m_result,
   input  logic                 stat_clr,
   output logic [31:0]          stat_lookups,
   output logic [31:0]          stat_hits,
   output logic [31:0]          stat_misses
);

   if (DATA != NODE_W || KEY_W != LOOKUP_KEY_W || RES_W != LOOKUP_RES_W ||
       NEXT_ADDR > CHILD_W || STAGE_ID < 0) begin : g_bad_cfg
      $error("lookup_stage: unsupported parameter set");
   end

   // The read address is never registered so the memory's own output
   // register lines up with stage 1.
   assign mem_addr = s_ptr;

   // Stage 1
   logic             v1_q;
   logic [KEY_W-1:0] key1_q;
   logic             done1_q;
   logic             hit1_q;
   logic [RES_W-1:0] res1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;
         key1_q  <= '0;
         done1_q <= 1'b0;
         hit1_q  <= 1'b0;
         res1_q  <= '0;
      end else begin
         v1_q    <= s_valid;
         key1_q  <= s_key;
         done1_q <= s_done;
         hit1_q  <= s_hit;
         res1_q  <= s_result;
      end
   end

   // Stage 2 decision
   node_t     node;
   decision_e dec;
   logic      unused_rsvd;

   assign node        = node_t'(mem_dout);
   assign unused_rsvd = ^node.rsvd;

   always_comb begin
      dec = DEC_RIGHT;
      if (done1_q)                 dec = DEC_PASS;
      else if (!node.nvalid)       dec = DEC_MISS;
      else if (key1_q == node.pivot) dec = DEC_HIT;
      else if (key1_q < node.pivot)  dec = DEC_LEFT;
   end

   logic [NEXT_ADDR-1:0] ptr_d;
   logic                 done_d;
   logic                 hit_d;
   logic [RES_W-1:0]     res_d;

   always_comb begin
      ptr_d  = '0;
      done_d = 1'b1;
      hit_d  = 1'b0;
      res_d  = '0;
      unique case (dec)
         DEC_PASS: begin
            hit_d = hit1_q;
            res_d = res1_q;
         end
         DEC_MISS: ;
         DEC_HIT: begin
            hit_d = 1'b1;
            res_d = node.result;
         end
         DEC_LEFT: begin
            ptr_d  = node.left[NEXT_ADDR-1:0];
            done_d = 1'b0;
         end
         default: begin
            ptr_d  = node.right[NEXT_ADDR-1:0];
            done_d = 1'b0;
         end
      endcase
   end

   logic                 m_valid_q;
   logic [KEY_W-1:0]     m_key_q;
   logic [NEXT_ADDR-1:0] m_ptr_q;
   logic                 m_done_q;
   logic                 m_hit_q;
   logic [RES_W-1:0]     m_result_q;

   // Payload only loads on a valid beat so idle cycles hold the last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid_q  <= 1'b0;
         m_key_q    <= '0;
         m_ptr_q    <= '0;
         m_done_q   <= 1'b0;
         m_hit_q    <= 1'b0;
         m_result_q <= '0;
      end else begin
         m_valid_q <= v1_q;
         if (v1_q) begin
            m_key_q    <= key1_q;
            m_ptr_q    <= ptr_d;
            m_done_q   <= done_d;
            m_hit_q    <= hit_d;
            m_result_q <= res_d;
         end
      end
   end

   assign m_valid  = m_valid_q;
   assign m_key    = m_key_q;
   assign m_ptr    = m_ptr_q;
   assign m_done   = m_done_q;
   assign m_hit    = m_hit_q;
   assign m_result = m_result_q;

   // Statistics: only beats still unresolved on entry are counted.
   logic inc_lookup;
   logic inc_hit;
   logic inc_miss;

   assign inc_lookup = v1_q && !done1_q;
   assign inc_hit    = inc_lookup && (dec == DEC_HIT);
   assign inc_miss   = inc_lookup && (dec == DEC_MISS);

   sat_counter #(.WIDTH(32)) u_cnt_lookups (
      .clk_i(clk), .rst_i(rst), .inc_i(inc_lookup), .clr_i(stat_clr), .count_o(stat_lookups)
   );

   sat_counter #(.WIDTH(32)) u_cnt_hits (
      .clk_i(clk), .rst_i(rst), .inc_i(inc_hit), .clr_i(stat_clr), .count_o(stat_hits)
   );

   sat_counter #(.WIDTH(32)) u_cnt_misses (
      .clk_i(clk), .rst_i(rst), .inc_i(inc_miss), .clr_i(stat_clr), .count_o(stat_misses)
   );

endmodule

// File: tb/tb_lookup_stage.sv
module tb_lookup_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic [31:0] s_key = '0;
   logic [9:0]  s_ptr = '0;
   logic        s_done = 1'b0;
   logic        s_hit = 1'b0;
   logic [15:0] s_result = '0;
   logic [9:0]  mem_addr;
   logic [71:0] mem_dout = '0;
   logic        m_valid;
   logic [31:0] m_key;
   logic [9:0]  m_ptr;
   logic        m_done;
   logic        m_hit;
   logic [15:0] m_result;
   logic        stat_clr = 1'b0;
   logic [31:0] stat_lookups, stat_hits, stat_misses;

   logic        sc_inc = 1'b0;
   logic        sc_clr = 1'b0;
   logic [3:0]  sc_q;

   always #5 clk = ~clk;

   lookup_stage #(
      .STAGE_ID(0), .DATA(72), .ADDR(10), .NEXT_ADDR(10), .KEY_W(32), .RES_W(16)
   ) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_key(s_key), .s_ptr(s_ptr), .s_done(s_done),
      .s_hit(s_hit), .s_result(s_result),
      .mem_addr(mem_addr), .mem_dout(mem_dout),
      .m_valid(m_valid), .m_key(m_key), .m_ptr(m_ptr), .m_done(m_done),
      .m_hit(m_hit), .m_result(m_result),
      .stat_clr(stat_clr),
      .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_misses(stat_misses)
   );

   // Narrow instance so saturation is reachable in a few cycles.
   sat_counter #(.WIDTH(4)) u_sc (
      .clk_i(clk), .rst_i(rst), .inc_i(sc_inc), .clr_i(sc_clr), .count_o(sc_q)
   );

   // Stage memory: registered read on port A.
   logic [71:0] mem [1024];
   always @(posedge clk) mem_dout <= mem[mem_addr];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int pops  = 0;
   logic [9:0] drv_ptr = '0;

   // Reference model state
   typedef struct {
      logic [31:0] key;
      logic [9:0]  ptr;
      logic        done;
      logic        hit;
      logic [15:0] res;
      int          due;
      bit          il, ih, im;
   } exp_t;
   exp_t q[$];
   longint ml = 0, mh = 0, mm = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] key, input logic [9:0] ptr,
                                  input logic done, input logic hit,
                                  input logic [15:0] res, input int due);
      exp_t e;
      logic [71:0] w;
      logic [31:0] pivot;
      w = mem[ptr];
      pivot = w[71:40];
      e.key = key; e.due = due; e.il = 0; e.ih = 0; e.im = 0;
      e.ptr = '0; e.done = 1'b1; e.hit = 1'b0; e.res = '0;
      if (done) begin
         e.hit = hit; e.res = res;
      end else begin
         e.il = 1;
         if (!w[0]) e.im = 1;
         else if (key == pivot) begin
            e.ih = 1; e.hit = 1'b1; e.res = w[19:4];
         end else if (key < pivot) begin
            e.ptr = w[39:30]; e.done = 1'b0;
         end else begin
            e.ptr = w[29:20]; e.done = 1'b0;
         end
      end
      return e;
   endfunction

   function automatic longint sat32(input longint v);
      return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
   endfunction

   task automatic drive_beat(input logic [31:0] key, input logic [9:0] ptr,
                             input logic done, input logic hit, input logic [15:0] res);
      s_valid = 1'b1; s_key = key; s_ptr = ptr; s_done = done; s_hit = hit; s_result = res;
      drv_ptr = ptr;
      q.push_back(model(key, ptr, done, hit, res, cyc + 2));
   endtask

   task automatic drive_idle();
      s_valid = 1'b0;
      s_key = $urandom;
      s_ptr = 10'($urandom);
      s_done = 1'($urandom);
      drv_ptr = s_ptr;
   endtask

   task automatic tick();
      logic rst_seen, clr_seen;
      exp_t e;
      @(posedge clk);
      rst_seen = rst;
      clr_seen = stat_clr;
      #1;
      cyc++;
      chk("mem_addr", 64'(mem_addr), 64'(drv_ptr));
      if (rst_seen) begin
         q.delete();
         ml = 0; mh = 0; mm = 0;
         chk("rst_m_valid", 64'(m_valid), 64'd0);
      end else begin
         if (m_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_beat", 64'(m_valid), 64'd0);
            end else begin
               e = q.pop_front();
               pops++;
               chk("latency", 64'(cyc), 64'(e.due));
               chk("m_key", 64'(m_key), 64'(e.key));
               chk("m_ptr", 64'(m_ptr), 64'(e.ptr));
               chk("m_done", 64'(m_done), 64'(e.done));
               chk("m_hit", 64'(m_hit), 64'(e.hit));
               chk("m_result", 64'(m_result), 64'(e.res));
               ml = sat32(ml + e.il); mh = sat32(mh + e.ih); mm = sat32(mm + e.im);
            end
         end else if (q.size() > 0 && q[0].due <= cyc) begin
            chk("missing_beat", 64'(m_valid), 64'd1);
            void'(q.pop_front());
         end
         if (clr_seen) begin
            ml = 0; mh = 0; mm = 0;
         end
      end
      chk("stat_lookups", 64'(stat_lookups), 64'(ml));
      chk("stat_hits", 64'(stat_hits), 64'(mh));
      chk("stat_misses", 64'(stat_misses), 64'(mm));
   endtask

   typedef struct {
      logic [31:0] key;
      logic [9:0]  ptr;
      logic        done, hit;
      logic [15:0] res;
      logic [9:0]  e_ptr;
      logic        e_done, e_hit;
      logic [15:0] e_res;
      int          dl, dh, dm;
   } vec_t;
   vec_t tbl[8];

   initial begin
      int sl, sh, sm;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      // node 3: pivot 0x40, left 5, right 9, result 0xBEEF, valid
      mem[3] = {32'h40, 10'd5, 10'd9, 16'hBEEF, 3'b000, 1'b1};
      mem[4] = {32'h40, 10'd7, 10'd8, 16'hCAFE, 3'b111, 1'b0};
      mem[6] = {32'hFFFF_FFFF, 10'h3FF, 10'd1, 16'h1234, 3'b101, 1'b1};
      for (int i = 16; i < 32; i++)
         mem[i] = {32'($urandom_range(0, 7)), 10'($urandom), 10'($urandom),
                   16'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0)};

      tbl[0] = '{32'h50, 10'd3, 0, 0, 16'h0,    10'd9,   0, 0, 16'h0,    1, 0, 0};
      tbl[1] = '{32'h40, 10'd3, 0, 0, 16'h0,    10'd0,   1, 1, 16'hBEEF, 1, 1, 0};
      tbl[2] = '{32'h30, 10'd3, 0, 0, 16'h0,    10'd5,   0, 0, 16'h0,    1, 0, 0};
      tbl[3] = '{32'h40, 10'd4, 0, 0, 16'h0,    10'd0,   1, 0, 16'h0,    1, 0, 1};
      tbl[4] = '{32'h77, 10'd3, 1, 1, 16'h5A5A, 10'd0,   1, 1, 16'h5A5A, 0, 0, 0};
      tbl[5] = '{32'hFFFF_FFFF, 10'd6, 0, 0, 16'h0, 10'd0, 1, 1, 16'h1234, 1, 1, 0};
      tbl[6] = '{32'hFFFF_FFFE, 10'd6, 0, 0, 16'h0, 10'h3FF, 0, 0, 16'h0, 1, 0, 0};
      tbl[7] = '{32'h0,  10'd3, 0, 0, 16'h0,    10'd5,   0, 0, 16'h0,    1, 0, 0};

      // Reset
      drive_idle();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("reset_m_valid", 64'(m_valid), 64'd0);
      chk("reset_m_key", 64'(m_key), 64'd0);
      chk("reset_m_ptr", 64'(m_ptr), 64'd0);
      chk("reset_m_done", 64'(m_done), 64'd0);
      chk("reset_m_hit", 64'(m_hit), 64'd0);
      chk("reset_m_result", 64'(m_result), 64'd0);
      chk("reset_lookups", 64'(stat_lookups), 64'd0);
      tick();

      // Directed vectors
      sl = 0; sh = 0; sm = 0;
      for (int i = 0; i < 8; i++) begin
         drive_beat(tbl[i].key, tbl[i].ptr, tbl[i].done, tbl[i].hit, tbl[i].res);
         tick();
         chk("vec_early_valid", 64'(m_valid), 64'd0);
         drive_idle();
         tick();
         sl += tbl[i].dl; sh += tbl[i].dh; sm += tbl[i].dm;
         chk("vec_valid", 64'(m_valid), 64'd1);
         chk("vec_key", 64'(m_key), 64'(tbl[i].key));
         chk("vec_ptr", 64'(m_ptr), 64'(tbl[i].e_ptr));
         chk("vec_done", 64'(m_done), 64'(tbl[i].e_done));
         chk("vec_hit", 64'(m_hit), 64'(tbl[i].e_hit));
         chk("vec_result", 64'(m_result), 64'(tbl[i].e_res));
         chk("vec_lookups", 64'(stat_lookups), 64'(sl));
         chk("vec_hits", 64'(stat_hits), 64'(sh));
         chk("vec_misses", 64'(stat_misses), 64'(sm));
         tick();
         chk("hold_valid", 64'(m_valid), 64'd0);
         chk("hold_ptr", 64'(m_ptr), 64'(tbl[i].e_ptr));
      end

      // 100 back-to-back beats alternating around pivot 0x40
      pops = 0;
      for (int i = 0; i < 100; i++) begin
         drive_beat((i % 2 == 0) ? 32'h10 : 32'h70, 10'd3, 1'b0, 1'b0, 16'h0);
         tick();
      end
      drive_idle();
      tick(); tick(); tick();
      chk("b2b_count", 64'(pops), 64'd100);
      chk("b2b_lookups", 64'(stat_lookups), 64'(sl + 100));

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            logic [9:0] p;
            logic [31:0] k;
            p = ($urandom_range(0, 7) == 0) ? 10'd3 : 10'($urandom_range(16, 31));
            k = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 8));
            drive_beat(k, p, 1'($urandom_range(0, 4) == 0), 1'($urandom), 16'($urandom));
         end else begin
            drive_idle();
         end
         tick();
      end
      drive_idle();
      tick(); tick();

      // stat_clr colliding with an increment
      drive_beat(32'h50, 10'd3, 1'b0, 1'b0, 16'h0);
      tick();
      drive_idle();
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk("clr_vs_inc_lookups", 64'(stat_lookups), 64'd0);
      chk("clr_vs_inc_hits", 64'(stat_hits), 64'd0);
      tick();

      // Reset with two beats in flight
      drive_beat(32'h50, 10'd3, 1'b0, 1'b0, 16'h0);
      tick();
      drive_beat(32'h30, 10'd3, 1'b0, 1'b0, 16'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive_beat(32'h40, 10'd3, 1'b0, 1'b0, 16'h0);
      tick();
      chk("flushed_beat", 64'(m_valid), 64'd0);
      drive_idle();
      tick();
      chk("post_rst_valid", 64'(m_valid), 64'd1);
      chk("post_rst_result", 64'(m_result), 64'hBEEF);
      tick();
      chk("post_rst_extra", 64'(m_valid), 64'd0);

      // Saturating counter behaviour on a narrow instance
      sc_inc = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         chk("sat_count", 64'(sc_q), 64'((i < 15) ? i : 15));
      end
      sc_clr = 1'b1;
      tick();
      chk("sat_clr_vs_inc", 64'(sc_q), 64'd0);
      sc_clr = 1'b0;
      tick();
      chk("sat_after_clr", 64'(sc_q), 64'd1);
      sc_inc = 1'b0;

      // Drain with a bounded wait
      for (int i = 0; i < 10 && q.size() > 0; i++) tick();
      chk("drain_empty", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
